// File: rtl/ice_cream_pkg.sv
// Shared encodings for the ice-cream vending path.
// Ball codes are common to the vending FSM and the dispenser.
package ice_cream_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CUP,
    S_SCOOP,
    S_WAIT_DONE,
    S_FAULT
  } state_t;

  typedef logic [1:0] balls_t;

  localparam balls_t BALLS_NONE = 2'd0;
  localparam balls_t BALLS_ONE  = 2'd1;
  localparam balls_t BALLS_TWO  = 2'd2;

  function automatic logic is_order(balls_t b);
    return (b == BALLS_ONE) || (b == BALLS_TWO);
  endfunction

endpackage

// File: rtl/order_fifo.sv
// Small order queue; push and pop may coincide, even when full.
// DEPTH must be a power of two, at least 2.
module order_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ice_cream_dispenser.sv
// Cup release and scoop-motor sequencer behind the vending FSM.
// Orders are queued; one is served at a time with timeout fault.
module ice_cream_dispenser
  import ice_cream_pkg::*;
#(
  parameter int SCOOP_CYCLES = 8,
  parameter int TIMEOUT      = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  ice_cream_balls,
  input  logic                        scoop_done,
  input  logic                        fault_clear,
  output logic                        cup_release,
  output logic                        motor_on,
  output logic                        busy,
  output logic                        fault,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] pending,
  output logic [7:0]                  balls_served
);

  localparam int CNT_MAX =
    (SCOOP_CYCLES > TIMEOUT) ? SCOOP_CYCLES : TIMEOUT;
  localparam int CNTW = $clog2(CNT_MAX + 1);

  state_t          state;
  balls_t          balls_q;
  balls_t          fifo_dout;
  logic [1:0]      remain;
  logic [CNTW-1:0] cnt;
  logic            armed;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;

  // armed masks the first edge after reset so a held value is not an order
  assign push = armed && is_order(ice_cream_balls)
             && (ice_cream_balls != balls_q);
  assign pop  = (state == S_IDLE) && !fifo_empty;

  order_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ice_cream_balls),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      balls_q  <= BALLS_NONE;
      armed    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      balls_q  <= ice_cream_balls;
      armed    <= 1'b1;
      overflow <= push && fifo_full && !pop;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      remain       <= '0;
      cnt          <= '0;
      cup_release  <= 1'b0;
      motor_on     <= 1'b0;
      busy         <= 1'b0;
      fault        <= 1'b0;
      balls_served <= '0;
    end else begin
      cup_release <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            remain      <= fifo_dout;
            state       <= S_CUP;
            cup_release <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_CUP: begin
          state    <= S_SCOOP;
          cnt      <= CNTW'(SCOOP_CYCLES - 1);
          motor_on <= 1'b1;
        end
        S_SCOOP: begin
          if (cnt == '0) begin
            state    <= S_WAIT_DONE;
            cnt      <= CNTW'(TIMEOUT - 1);
            motor_on <= 1'b0;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        S_WAIT_DONE: begin
          // a confirmation on the expiry cycle still counts
          if (scoop_done) begin
            balls_served <= balls_served + 8'd1;
            remain       <= remain - 2'd1;
            if (remain == 2'd1) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= S_SCOOP;
              cnt      <= CNTW'(SCOOP_CYCLES - 1);
              motor_on <= 1'b1;
            end
          end else if (cnt == '0) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            cnt <= cnt - CNTW'(1);
          end
        end
        S_FAULT: begin
          if (fault_clear) begin
            state <= S_IDLE;
            fault <= 1'b0;
            busy  <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          motor_on <= 1'b0;
          fault    <= 1'b0;
        end
      endcase
    end
  end

endmodule
